// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchroniser plus per-bit stability counter for raw slide switches,
// with a one-cycle change strobe and per-bit rising-edge flags.
module switch_debouncer #(
   parameter  int WIDTH         = 8,
   parameter  int STABLE_CYCLES = 4,
   localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic             clock,
   input  logic             n_reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw,
   output logic             sw_changed,
   output logic [WIDTH-1:0] sw_rise
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   logic [WIDTH-1:0] r_sync1, r_sync2, r_sw, r_rise;
   logic             r_changed;
   logic [CNT_W-1:0] r_cnt [WIDTH];
   logic [WIDTH-1:0] w_diff, w_done;
   assign w_diff = r_sync2 ^ r_sw;
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_sw      <= '0;
         r_rise    <= '0;
         r_changed <= 1'b0;
      end else begin
         r_sync1   <= sw_raw;
         r_sync2   <= r_sync1;
         r_sw      <= r_sw ^ w_done;
         r_rise    <= w_done & r_sync2;
         r_changed <= |w_done;
      end
   end
   // Counter restarts on agreement and on each accepted update, so it never wraps.
   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      assign w_done[g] = w_diff[g] & (r_cnt[g] == CNT_MAX);
      always_ff @(posedge clock or negedge n_reset) begin
         if (!n_reset) r_cnt[g] <= '0;
         else          r_cnt[g] <= (!w_diff[g] || w_done[g]) ? '0 : r_cnt[g] + CNT_W'(1);
      end
   end
   assign sw         = r_sw;
   assign sw_changed = r_changed;
   assign sw_rise    = r_rise;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed vectors with hand-computed expectations for switch_debouncer
// (STABLE_CYCLES = 4, 20 ns clock).
module tb_switch_debouncer;
   logic       clock = 1'b0;
   logic       n_reset = 1'b1;
   logic [7:0] sw_raw = 8'h00;
   logic [7:0] sw, sw_rise;
   logic       sw_changed;
   int         errors = 0;
   int         checks = 0;

   switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(4)) dut (
      .clock(clock), .n_reset(n_reset), .sw_raw(sw_raw),
      .sw(sw), .sw_changed(sw_changed), .sw_rise(sw_rise)
   );

   always #10 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Pulse bit 3 high for n cycles; edge t=0 is the first edge that samples it.
   task automatic glitch(input int n);
      int up, dn;
      up = (n >= 4) ? 5 : 99;
      dn = (n >= 4) ? n + 5 : 99;
      sw_raw = 8'h08;
      for (int t = 0; t < 12; t++) begin
         tick();
         check($sformatf("glitch%0d_sw_t%0d", n, t), sw, (t >= up && t < dn) ? 8'h08 : 8'h00);
         check($sformatf("glitch%0d_chg_t%0d", n, t), sw_changed, (t == up || t == dn) ? 1 : 0);
         check($sformatf("glitch%0d_rise_t%0d", n, t), sw_rise, (t == up) ? 8'h08 : 8'h00);
         if (t == n - 1) sw_raw = 8'h00;
      end
   endtask

   initial begin
      int pat [6] = '{1, 0, 1, 1, 0, 1};
      // Reset with no clock edge
      #1 n_reset = 1'b0;
      #1;
      check("reset_async", {sw, sw_changed, sw_rise}, 0);
      #1 n_reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("reset_idle_%0d", i), {sw, sw_changed, sw_rise}, 0);
      end
      // Clean rising change on bits 0 and 2
      sw_raw = 8'h05;
      for (int t = 0; t < 7; t++) begin
         tick();
         check($sformatf("clean_sw_t%0d", t), sw, (t >= 5) ? 8'h05 : 8'h00);
         check($sformatf("clean_chg_t%0d", t), sw_changed, (t == 5) ? 1 : 0);
         check($sformatf("clean_rise_t%0d", t), sw_rise, (t == 5) ? 8'h05 : 8'h00);
      end
      // Falling change: strobe without rise flags
      sw_raw = 8'h00;
      for (int t = 0; t < 7; t++) begin
         tick();
         check($sformatf("fall_sw_t%0d", t), sw, (t >= 5) ? 8'h00 : 8'h05);
         check($sformatf("fall_chg_t%0d", t), sw_changed, (t == 5) ? 1 : 0);
         check($sformatf("fall_rise_t%0d", t), sw_rise, 8'h00);
      end
      glitch(3);
      glitch(4);
      // Bounce on bit 7, then settle high
      for (int t = 0; t < 14; t++) begin
         sw_raw = (t < 6) ? {pat[t][0], 7'b0} : 8'h80;
         tick();
         check($sformatf("bounce_sw_t%0d", t), sw, (t >= 10) ? 8'h80 : 8'h00);
         check($sformatf("bounce_chg_t%0d", t), sw_changed, (t == 10) ? 1 : 0);
         check($sformatf("bounce_rise_t%0d", t), sw_rise, (t == 10) ? 8'h80 : 8'h00);
      end
      // Asynchronous reset clears a settled word
      sw_raw = 8'h00;
      n_reset = 1'b0;
      #2;
      check("reset_clears_sw", sw, 8'h00);
      n_reset = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      // Reset mid-count on bit 0: two counted cycles then reset
      sw_raw = 8'h01;
      for (int t = 0; t < 4; t++) begin
         tick();
         check($sformatf("midcnt_sw_t%0d", t), sw, 8'h00);
      end
      n_reset = 1'b0;
      #2;
      check("midcnt_in_reset", {sw, sw_changed, sw_rise}, 0);
      tick();
      check("midcnt_held_reset", {sw, sw_changed, sw_rise}, 0);
      n_reset = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         check($sformatf("postrst_sw_e%0d", e), sw, (e >= 6) ? 8'h01 : 8'h00);
         check($sformatf("postrst_chg_e%0d", e), sw_changed, (e == 6) ? 1 : 0);
         check($sformatf("postrst_rise_e%0d", e), sw_rise, (e == 6) ? 8'h01 : 8'h00);
      end
      // Simultaneous rising and falling bits from 8'hF0
      sw_raw = 8'hF0;
      for (int i = 0; i < 10; i++) tick();
      check("simul_start", sw, 8'hF0);
      sw_raw = 8'h0F;
      for (int t = 0; t < 8; t++) begin
         tick();
         check($sformatf("simul_sw_t%0d", t), sw, (t >= 5) ? 8'h0F : 8'hF0);
         check($sformatf("simul_chg_t%0d", t), sw_changed, (t == 5) ? 1 : 0);
         check($sformatf("simul_rise_t%0d", t), sw_rise, (t == 5) ? 8'h0F : 8'h00);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
